filter2d_ctrl: RTL and testbench
================================

FILTER2D_CTRL -- requirements
Module: filter2d_ctrl

Interface
REQ-001 Parameter WIDTH, default 128, image side in pixels; legal range 4..255.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles allowed between filter output strobes; legal range 16..1023.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 n_reset  input  1  reset, synchronous, active-low.
REQ-005 cfg_we  input  1  coefficient shadow write strobe.
REQ-006 cfg_idx  input  4  shadow index 0..8; writes with idx>8 are ignored.
REQ-007 cfg_data  input  8  signed coefficient.
REQ-008 go  input  1  run request pulse.
REQ-009 abort  input  1  cancel the current run.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a frame completes.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 pix_cnt  output  16  pixels written in the current or last run.
REQ-014 f_h_write / f_h_idx / f_h_data  output  1/4/8  filter coefficient write port.
REQ-015 f_start  output  1  filter start pulse.
REQ-016 f_o_strb / f_o_data  input  1/8  filter result strobe and pixel.
REQ-017 wr_en / wr_addr / wr_data  output  1/16/8  output frame memory write port.

Function
REQ-018 The state machine SHALL have the states IDLE, LOAD, START, RUN, DONE, ERR and QUIESCE.
REQ-019 IDLE: go moves to LOAD if coef_dirty=1, else to START; go in any other state is ignored.
REQ-020 LOAD: on entry, clear coef_dirty; over 9 consecutive cycles issue f_h_write=1 with f_h_idx=0..8 and f_h_data=shadow[idx] sampled in that cycle; then go to START.
REQ-021 START: assert f_start for exactly 1 cycle, clear pix_cnt and the output address, then go to RUN.
REQ-022 RUN: each f_o_strb causes wr_en=1 on the next cycle, with wr_data=f_o_data and wr_addr=current address; then address and pix_cnt each increment by 1.
REQ-023 RUN SHALL go to DONE in the cycle after the write for pixel WIDTH*WIDTH-1 (address 0 upward, raster order).
REQ-024 DONE: assert done for 1 cycle, then go to IDLE.
REQ-025 Watchdog: the counter clears on START entry and on each f_o_strb, and increments otherwise in RUN; when it reaches TIMEOUT, set err=1 and go to ERR.
REQ-026 ERR: hold until go (clears err and goes to QUIESCE) or abort (clears err and goes to QUIESCE).
REQ-027 abort in LOAD, START or RUN goes to QUIESCE on the next cycle; no done is produced; abort has priority over a simultaneous strobe or completion.
REQ-028 QUIESCE: wr_en is held 0 and strobes are discarded; go to IDLE once TIMEOUT consecutive cycles pass with no f_o_strb.
REQ-029 In IDLE and DONE, f_o_strb is ignored and no write is issued.
REQ-030 Shadow coefficients:
- cfg_we is accepted in every state and always sets coef_dirty.
- A write landing in LOAD after its index was issued leaves coef_dirty=1 for the next run.
- The shadow initial values are {08,10,08,10,20,10,08,10,08} hex, with coef_dirty=1.
REQ-031 cfg_we to an index in the same cycle LOAD issues that index: f_h_data carries the old value, and the shadow takes the new value.
REQ-032 The wr_addr and pix_cnt arithmetic SHALL be 16-bit unsigned with no wrap within a frame.

Reset
REQ-033 When n_reset=0 at a clock edge, the block SHALL enter IDLE and set:
- busy=0, done=0, err=0, pix_cnt=0.
- f_h_write=0, f_h_idx=0, f_h_data=0, f_start=0.
- wr_en=0, wr_addr=0, wr_data=0.
- watchdog=0, shadow to its initial values, coef_dirty=1.
REQ-034 Reset mid-run SHALL take effect within 1 cycle, with no done and no further writes.

Structure
REQ-035 The shared filter2d package SHALL hold the state enum, the 9-tap count, the initial coefficient table and the pixel/coefficient width constants.
REQ-036 The watchdog SHALL be one sub-module, filter2d_wdog (load/clear/expire), reused for RUN and QUIESCE.

Verification (WIDTH=4, TIMEOUT=64)
REQ-037 Reset, then go → 9 f_h_write cycles with idx 0..8 and data 08,10,08,10,20,10,08,10,08, then 1 f_start cycle.
REQ-038 Model filter produces 16 strobes every 12 cycles → wr_addr 0..15, data matching, done pulse once, pix_cnt=16, busy low after.
REQ-039 Second go with no cfg_we → no LOAD, f_start 1 cycle after go; cfg_we idx=4 data=0x40 then go → LOAD issues idx4=0x40.
REQ-040 Model stops after 5 strobes → err=1 exactly 64 cycles after the 5th strobe; go → err=0, QUIESCE, IDLE after 64 quiet cycles.
REQ-041 abort after pixel 7 while the model keeps strobing → no writes beyond addr 6 (or 7 if same cycle), no done; IDLE 64 cycles after the last strobe.
REQ-042 n_reset low for 1 cycle during RUN → all outputs reach reset values on the next edge; cfg_we idx=9 → shadow unchanged.

Source files
------------

// File: rtl/filter2d_pkg.sv
// Shared definitions for the 2-D filter controller.
// Holds the controller state encoding, tap count, the power-on coefficient
// table and the pixel / coefficient / address / watchdog width constants.
package filter2d_pkg;

    localparam int unsigned NumTaps = 9;
    localparam int unsigned TapIdxW = 4;
    localparam int unsigned PixW    = 8;
    localparam int unsigned CoefW   = 8;
    localparam int unsigned AddrW   = 16;
    localparam int unsigned WdogW   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StDone,
        StErr,
        StQuiesce
    } state_e;

    // Element [i] is the coefficient for tap i (table is symmetric).
    localparam logic [NumTaps-1:0][CoefW-1:0] CoefInit = {
        8'h08, 8'h10, 8'h08,
        8'h10, 8'h20, 8'h10,
        8'h08, 8'h10, 8'h08
    };

endpackage

// File: rtl/filter2d_wdog.sv
// Inactivity watchdog shared by the RUN and QUIESCE phases.
// Ports:
//   clk, n_reset : clock, synchronous active-low reset
//   clr_i        : force count to 0
//   load_i       : force count to 1 (the cycle carrying activity counts as elapsed)
//   en_i         : count one more idle cycle (saturates at TIMEOUT)
//   expire_o     : the next enabled increment reaches TIMEOUT
module filter2d_wdog
    import filter2d_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WdogW-1:0] Limit   = WdogW'(TIMEOUT);
    localparam logic [WdogW-1:0] LastCnt = WdogW'(TIMEOUT - 1);

    logic [WdogW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = WdogW'(1);
        end else if (en_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + WdogW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LastCnt);

endmodule

// File: rtl/filter2d_ctrl.sv
// Run controller for an external 2-D filter.
// Loads the 9 shadow coefficients into the filter when they changed, starts
// it, writes each returned pixel to the output frame memory in raster order
// and guards the run with an inactivity watchdog.
// Ports:
//   clk, n_reset                 : clock, synchronous active-low reset
//   cfg_we/cfg_idx/cfg_data      : coefficient shadow write
//   go, abort                    : run request / cancel
//   busy, done, err, pix_cnt     : status
//   f_h_write/f_h_idx/f_h_data   : filter coefficient write port
//   f_start                      : filter start pulse
//   f_o_strb/f_o_data            : filter result stream
//   wr_en/wr_addr/wr_data        : output frame memory write port
module filter2d_ctrl
    import filter2d_pkg::*;
#(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               cfg_we,
    input  logic [TapIdxW-1:0] cfg_idx,
    input  logic [CoefW-1:0]   cfg_data,
    input  logic               go,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AddrW-1:0]   pix_cnt,
    output logic               f_h_write,
    output logic [TapIdxW-1:0] f_h_idx,
    output logic [CoefW-1:0]   f_h_data,
    output logic               f_start,
    input  logic               f_o_strb,
    input  logic [PixW-1:0]    f_o_data,
    output logic               wr_en,
    output logic [AddrW-1:0]   wr_addr,
    output logic [PixW-1:0]    wr_data
);

    localparam logic [AddrW-1:0]   FramePix = AddrW'(WIDTH * WIDTH);
    localparam logic [TapIdxW-1:0] LastTap  = TapIdxW'(NumTaps - 1);

    state_e                           state_q, state_d;
    logic [TapIdxW-1:0]               ld_idx_q, ld_idx_d;
    logic [NumTaps-1:0][CoefW-1:0]    shadow_q, shadow_d;
    logic                             coef_dirty_q, coef_dirty_d;
    logic                             err_q, err_d;
    logic [AddrW-1:0]                 pix_cnt_q, pix_cnt_d;
    logic                             wr_en_q, wr_en_d;
    logic [AddrW-1:0]                 wr_addr_q, wr_addr_d;
    logic [PixW-1:0]                  wr_data_q, wr_data_d;

    logic             cfg_valid;
    logic [CoefW-1:0] tap_data;
    logic             wd_clr, wd_load, wd_en, wd_expire;

    assign cfg_valid = cfg_we && (cfg_idx < TapIdxW'(NumTaps));

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NumTaps; i++) begin
            if (cfg_we && (cfg_idx == TapIdxW'(i))) begin
                shadow_d[i] = cfg_data;
            end
        end
    end

    // Reads the registered shadow, so a same-cycle write is seen on the next load.
    always_comb begin
        tap_data = '0;
        for (int i = 0; i < NumTaps; i++) begin
            if (ld_idx_q == TapIdxW'(i)) begin
                tap_data = shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_idx_d     = ld_idx_q;
        coef_dirty_d = coef_dirty_q;
        err_d        = err_q;
        pix_cnt_d    = pix_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wd_clr       = 1'b0;
        wd_load      = 1'b0;
        wd_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    ld_idx_d = '0;
                    if (coef_dirty_q) begin
                        coef_dirty_d = 1'b0;
                        state_d      = StLoad;
                    end else begin
                        state_d = StStart;
                    end
                end
            end
            StLoad: begin
                if (abort) begin
                    wd_clr  = 1'b1;
                    state_d = StQuiesce;
                end else if (ld_idx_q == LastTap) begin
                    state_d = StStart;
                end else begin
                    ld_idx_d = ld_idx_q + TapIdxW'(1);
                end
            end
            StStart: begin
                wd_clr    = 1'b1;
                pix_cnt_d = '0;
                wr_addr_d = '0;
                state_d   = abort ? StQuiesce : StRun;
            end
            StRun: begin
                if (abort) begin
                    // A strobe in the abort cycle still counts as activity.
                    wd_load = f_o_strb;
                    wd_clr  = !f_o_strb;
                    state_d = StQuiesce;
                end else if (pix_cnt_q == FramePix) begin
                    // This is the cycle carrying the last pixel's write.
                    state_d = StDone;
                end else if (f_o_strb) begin
                    wd_load   = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = f_o_data;
                    pix_cnt_d = pix_cnt_q + AddrW'(1);
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                if (go || abort) begin
                    err_d   = 1'b0;
                    wd_clr  = 1'b1;
                    state_d = StQuiesce;
                end
            end
            StQuiesce: begin
                if (f_o_strb) begin
                    wd_load = 1'b1;
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any accepted shadow write re-arms the load, even one landing during LOAD.
        if (cfg_valid) begin
            coef_dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= StIdle;
            ld_idx_q     <= '0;
            shadow_q     <= CoefInit;
            coef_dirty_q <= 1'b1;
            err_q        <= 1'b0;
            pix_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            ld_idx_q     <= ld_idx_d;
            shadow_q     <= shadow_d;
            coef_dirty_q <= coef_dirty_d;
            err_q        <= err_d;
            pix_cnt_q    <= pix_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    filter2d_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .n_reset  (n_reset),
        .clr_i    (wd_clr),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign f_start   = (state_q == StStart);
    assign f_h_write = (state_q == StLoad);
    assign f_h_idx   = f_h_write ? ld_idx_q : '0;
    assign f_h_data  = f_h_write ? tap_data : '0;
    assign err       = err_q;
    assign pix_cnt   = pix_cnt_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_filter2d_ctrl.sv
// Self-checking bench for filter2d_ctrl (WIDTH=4, TIMEOUT=64).
// Expected memory writes and coefficient writes are queued when stimulus is
// driven and popped by a negedge monitor when the DUT produces them.
module tb_filter2d_ctrl;

    localparam int unsigned Width   = 4;
    localparam int unsigned Timeout = 64;
    localparam int unsigned NPix    = Width * Width;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset, cfg_we, go, abort, f_o_strb;
    logic [3:0]  cfg_idx;
    logic [7:0]  cfg_data, f_o_data;
    logic        busy, done, err, f_h_write, f_start, wr_en;
    logic [15:0] pix_cnt, wr_addr;
    logic [3:0]  f_h_idx;
    logic [7:0]  f_h_data, wr_data;

    filter2d_ctrl #(
        .WIDTH   (Width),
        .TIMEOUT (Timeout)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .go        (go),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pix_cnt   (pix_cnt),
        .f_h_write (f_h_write),
        .f_h_idx   (f_h_idx),
        .f_h_data  (f_h_data),
        .f_start   (f_start),
        .f_o_strb  (f_o_strb),
        .f_o_data  (f_o_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_hw = 0;
    logic [23:0] wq[$];
    logic [11:0] hq[$];
    logic [23:0] w_exp;
    logic [11:0] h_exp;
    logic [7:0]  sh[9];
    logic        dirty_m;
    logic [15:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write the DUT issues must match the queue head.
    always @(negedge clk) begin
        if (done) n_done++;
        if (wr_en) begin
            chk("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                w_exp = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(w_exp[23:8]));
                chk("wr_data", 32'(wr_data), 32'(w_exp[7:0]));
            end
        end
        if (f_h_write) begin
            n_hw++;
            chk("fh_expected", 32'(hq.size() != 0), 32'd1);
            if (hq.size() != 0) begin
                h_exp = hq.pop_front();
                chk("fh_idx", 32'(f_h_idx), 32'(h_exp[11:8]));
                chk("fh_data", 32'(f_h_data), 32'(h_exp[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sh = '{8'h08, 8'h10, 8'h08, 8'h10, 8'h20, 8'h10, 8'h08, 8'h10, 8'h08};
        dirty_m = 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [7:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
        tick();
        cfg_we = 1'b0;
        if (idx < 4'd9) begin
            sh[idx] = data;
            dirty_m = 1'b1;
        end
    endtask

    // which: 0 f_start, 1 done, 2 err, 3 idle. cnt = negedges until the event.
    task automatic wait_sig(input int which, input int budget, output int cnt);
        bit hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < budget) begin
            @(negedge clk);
            cnt++;
            case (which)
                0:       hit = f_start;
                1:       hit = done;
                2:       hit = err;
                default: hit = !busy;
            endcase
        end
        chk($sformatf("wait_hit_%0d", which), 32'(hit), 32'd1);
    endtask

    task automatic push_load();
        for (int i = 0; i < 9; i++) hq.push_back({4'(i), sh[i]});
        dirty_m = 1'b0;
    endtask

    task automatic do_go();
        int cnt;
        int lat;
        lat = dirty_m ? 10 : 1;
        if (dirty_m) push_load();
        exp_addr = '0;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_sig(0, 40, cnt);
        chk("start_lat", 32'(cnt), 32'(lat));
        @(negedge clk);
        chk("start_width", 32'(f_start), 32'd0);
    endtask

    task automatic strobe_seq(input int n, input int period, input int n_push);
        for (int k = 0; k < n; k++) begin
            repeat (period - 1) tick();
            f_o_strb = 1'b1;
            f_o_data = 8'($urandom);
            if (k < n_push) begin
                wq.push_back({exp_addr, f_o_data});
                exp_addr = exp_addr + 16'd1;
            end
            tick();
            f_o_strb = 1'b0;
        end
    endtask

    task automatic check_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
        chk("rst_fh_write", 32'(f_h_write), 32'd0);
        chk("rst_fh_idx", 32'(f_h_idx), 32'd0);
        chk("rst_fh_data", 32'(f_h_data), 32'd0);
        chk("rst_f_start", 32'(f_start), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
    endtask

    task automatic finish_frame(input string tag, input int exp_done);
        int cnt;
        // Write lands the cycle after the last strobe, DONE the cycle after that.
        wait_sig(1, 10, cnt);
        chk({tag, "_done_lat"}, 32'(cnt), 32'd2);
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pix_cnt"}, 32'(pix_cnt), 32'(NPix));
        chk({tag, "_done_cnt"}, 32'(n_done), 32'(exp_done));
        chk({tag, "_wq"}, 32'(wq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int nd;
        n_reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
        go = 1'b0; abort = 1'b0; f_o_strb = 1'b0; f_o_data = '0;
        exp_addr = '0;
        model_reset();
        repeat (2) tick();
        @(negedge clk);
        check_reset();
        n_reset = 1'b1;
        tick();

        // Frame 1: initial coefficients loaded, slow filter.
        do_go();
        strobe_seq(NPix, 12, NPix);
        finish_frame("f1", 1);
        chk("f1_fh_count", 32'(n_hw), 32'd9);

        // Frame 2: clean shadow, no load.
        do_go();
        strobe_seq(NPix, 3, NPix);
        finish_frame("f2", 2);
        chk("f2_fh_count", 32'(n_hw), 32'd9);

        // Frame 3: idx4 rewritten, then rewritten again as LOAD issues idx4.
        cfg_write(4'd4, 8'h40);
        push_load();
        exp_addr = '0;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (4) tick();
        cfg_write(4'd4, 8'h55);
        wait_sig(0, 20, cnt);
        chk("f3_start_lat", 32'(cnt), 32'd5);
        @(negedge clk);
        strobe_seq(NPix, 2, NPix);
        finish_frame("f3", 3);

        // Watchdog: 5 pixels then silence; reloads 0x55 left dirty above.
        do_go();
        strobe_seq(5, 4, 5);
        wait_sig(2, 100, cnt);
        chk("err_lat", 32'(cnt), 32'(Timeout));
        chk("err_busy", 32'(busy), 32'd1);
        go = 1'b1;
        tick();
        go = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        chk("quiesce_busy", 32'(busy), 32'd1);
        wait_sig(3, 200, cnt);
        chk("quiesce_len", 32'(cnt), 32'(Timeout));
        chk("err_pix_cnt", 32'(pix_cnt), 32'd5);

        // Abort after the 7th pixel while the filter keeps streaming.
        nd = n_done;
        do_go();
        strobe_seq(7, 4, 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        strobe_seq(5, 4, 0);
        wait_sig(3, 200, cnt);
        chk("abort_idle", 32'(cnt), 32'(Timeout));
        chk("abort_no_done", 32'(n_done), 32'(nd));
        chk("abort_pix_cnt", 32'(pix_cnt), 32'd7);

        // Reset pulse mid-run with a strobe pending.
        do_go();
        strobe_seq(3, 4, 3);
        repeat (2) tick();
        n_reset = 1'b0;
        f_o_strb = 1'b1;
        f_o_data = 8'hA5;
        tick();
        n_reset = 1'b1;
        f_o_strb = 1'b0;
        @(negedge clk);
        check_reset();
        model_reset();
        repeat (4) tick();
        chk("rst_no_done", 32'(n_done), 32'(nd));

        // Out-of-range index is ignored: reload shows the initial table.
        cfg_write(4'd9, 8'hFF);
        do_go();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        // QUIESCE is entered on this cycle's edge; idle after TIMEOUT quiet cycles.
        wait_sig(3, 200, cnt);
        chk("abort_run_idle", 32'(cnt), 32'(Timeout + 1));

        chk("end_hq", 32'(hq.size()), 32'd0);
        chk("end_wq", 32'(wq.size()), 32'd0);
        chk("end_err", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
